arb_grant_dispatch: RTL and testbench

Downstream stage of the 4-way round-robin arbiter. It samples the arbiter's one-hot grant and locks onto the winning requester for one burst. It then forwards that requester's data beats to a single shared sink through a one-entry registered output with valid/ready handshake. The lock keeps the burst intact while the arbiter's grant keeps rotating cycle by cycle.

---
 rtl/arb_pkg.sv | 33 +++
 rtl/arb_out_reg.sv | 54 +++++
 rtl/arb_grant_dispatch.sv | 140 ++++++++++++++
 tb/tb_arb_grant_dispatch.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Purpose: shared types, constants and grant helpers for the arbiter dispatch stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package arb_pkg;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int IDXW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Index of the highest set bit; only meaningful when the input is one-hot.
    function automatic logic [IDXW-1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
        logic [IDXW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) begin
                idx = IDXW'(i);
            end
        end
        return idx;
    endfunction

    // Non-zero with no second bit set: clearing the lowest set bit leaves zero.
    function automatic logic is_onehot(input logic [NREQ-1:0] v);
        return (v != '0) && ((v & (v - NREQ'(1))) == '0);
    endfunction

endpackage

// File: rtl/arb_out_reg.sv
// Purpose: one-entry registered sink slot holding data, source index and last flag.
// Latency: one cycle from load_i to vld_o.
// Backpressure: contents held until the owner asserts clr_i; load_i has priority over clr_i.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   load_i            capture dat_i/src_i/last_i and set vld_o
//   clr_i             drop vld_o (payload kept, it is don't-care while invalid)
//   dat_i/src_i/last_i incoming beat fields
//   vld_o/dat_o/src_o/last_o registered beat presented to the sink
module arb_out_reg #(
    parameter int DW = 8,
    parameter int SW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          clr_i,
    input  logic [DW-1:0] dat_i,
    input  logic [SW-1:0] src_i,
    input  logic          last_i,
    output logic          vld_o,
    output logic [DW-1:0] dat_o,
    output logic [SW-1:0] src_o,
    output logic          last_o
);

    logic          vld_q;
    logic [DW-1:0] dat_q;
    logic [SW-1:0] src_q;
    logic          last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            dat_q  <= '0;
            src_q  <= '0;
            last_q <= 1'b0;
        end else if (load_i) begin
            vld_q  <= 1'b1;
            dat_q  <= dat_i;
            src_q  <= src_i;
            last_q <= last_i;
        end else if (clr_i) begin
            vld_q  <= 1'b0;
        end
    end

    assign vld_o  = vld_q;
    assign dat_o  = dat_q;
    assign src_o  = src_q;
    assign last_o = last_q;

endmodule

// File: rtl/arb_grant_dispatch.sv
// Purpose: lock onto the arbiter's one-hot winner and forward its burst to one shared sink.
// Latency: grant seen at edge N, in_ready at N+1, first out_valid at N+2; one beat/cycle sustained.
// Backpressure: sink stall holds the output slot and drops in_ready[src] until out_ready returns.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   gnt           one-hot grant from the arbiter, sampled only while idle
//   in_valid/in_data/in_last/in_ready  per-requester beat handshake (requester i at bits [i*DW +: DW])
//   out_valid/out_data/out_src/out_last/out_ready  registered sink handshake
//   busy          a burst is locked (state not IDLE)
//   gnt_err       sticky: a multi-hot grant was seen while idle
module arb_grant_dispatch
    import arb_pkg::*;
#(
    parameter int DW        = arb_pkg::DW,
    parameter int NREQ      = arb_pkg::NREQ,
    parameter int MAX_BEATS = 4,
    parameter int SW        = $clog2(NREQ),
    parameter int BW        = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    gnt,
    input  logic [NREQ-1:0]    in_valid,
    input  logic [NREQ*DW-1:0] in_data,
    input  logic [NREQ-1:0]    in_last,
    output logic [NREQ-1:0]    in_ready,
    output logic               out_valid,
    output logic [DW-1:0]      out_data,
    output logic [SW-1:0]      out_src,
    output logic               out_last,
    input  logic               out_ready,
    output logic               busy,
    output logic               gnt_err
);

    state_e         state_q, state_d;
    logic [SW-1:0]  src_q, src_d;
    logic [BW-1:0]  beat_cnt_q, beat_cnt_d;
    logic           gnt_err_q, gnt_err_d;

    logic [NREQ-1:0] rdy;
    logic            accept;
    logic            load;
    logic            clr;
    logic            beat_last;

    logic            sel_vld;
    logic [DW-1:0]   sel_dat;
    logic            sel_last;

    // Mux of the locked requester; src_q only changes in IDLE so this is stable for a burst.
    assign sel_vld  = in_valid[src_q];
    assign sel_dat  = in_data[src_q*DW +: DW];
    assign sel_last = in_last[src_q];

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        beat_cnt_d = beat_cnt_q;
        gnt_err_d  = gnt_err_q;
        rdy        = '0;
        accept     = 1'b0;
        load       = 1'b0;
        clr        = 1'b0;
        // A burst closes on the requester's marker or when the beat budget is used up.
        beat_last  = sel_last || (beat_cnt_q == BW'(MAX_BEATS - 1));

        case (state_q)
            IDLE: begin
                if (is_onehot(gnt)) begin
                    src_d      = onehot_to_idx(gnt);
                    beat_cnt_d = '0;
                    state_d    = XFER;
                end else if (gnt != '0) begin
                    gnt_err_d  = 1'b1;
                end
            end
            XFER: begin
                // Slot is free if empty or being drained this cycle, so back-to-back beats flow.
                rdy[src_q] = !out_valid || out_ready;
                accept     = sel_vld && rdy[src_q];
                if (accept) begin
                    load       = 1'b1;
                    beat_cnt_d = beat_cnt_q + BW'(1);
                    if (beat_last) begin
                        state_d = DRAIN;
                    end
                end else if (out_valid && out_ready) begin
                    clr = 1'b1;
                end
            end
            DRAIN: begin
                if (!out_valid || out_ready) begin
                    clr     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            src_q      <= '0;
            beat_cnt_q <= '0;
            gnt_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            beat_cnt_q <= beat_cnt_d;
            gnt_err_q  <= gnt_err_d;
        end
    end

    arb_out_reg #(
        .DW (DW),
        .SW (SW)
    ) u_out_reg (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .clr_i  (clr),
        .dat_i  (sel_dat),
        .src_i  (src_q),
        .last_i (beat_last),
        .vld_o  (out_valid),
        .dat_o  (out_data),
        .src_o  (out_src),
        .last_o (out_last)
    );

    assign in_ready = rdy;
    assign busy     = (state_q != IDLE);
    assign gnt_err  = gnt_err_q;

endmodule

// File: tb/tb_arb_grant_dispatch.sv
// Purpose: directed bench for arb_grant_dispatch with a beat scoreboard and requester models.
// Latency: n/a.
// Backpressure: sink stalls are driven explicitly by the stimulus sequence.
module tb_arb_grant_dispatch;

    logic        clk;
    logic        rst;
    logic [3:0]  gnt;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_last;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_src;
    logic        out_last;
    logic        out_ready;
    logic        busy;
    logic        gnt_err;

    arb_grant_dispatch #(
        .DW        (8),
        .NREQ      (4),
        .MAX_BEATS (4),
        .SW        (2),
        .BW        (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .gnt       (gnt),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy),
        .gnt_err   (gnt_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] s;
        logic       l;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    // Requester models: each presents its beat list in order, advancing on handshake.
    logic [7:0] rq_d [4][4];
    logic       rq_l [4][4];
    int         rq_len [4];
    int         rq_idx [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic push(input logic [7:0] d, input logic [1:0] s, input logic l);
        exp_t e;
        e.d = d;
        e.s = s;
        e.l = l;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic load_req(input int r, input logic [7:0] base, input int len, input int last_at);
        for (int k = 0; k < 4; k++) begin
            rq_d[r][k] = base + 8'(k);
            rq_l[r][k] = (k == last_at);
        end
        rq_len[r] = len;
        rq_idx[r] = 0;
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 50; c++) begin
            smp();
            if (sb.size() == 0 && !busy && !out_valid) begin
                done = 1'b1;
                break;
            end
        end
        check(name, 32'(done), 32'd1);
    endtask

    // Requester driver: handshake sampled mid-cycle, new beat presented just after the edge.
    initial begin
        logic [3:0] hs;
        in_valid = '0;
        in_data  = '0;
        in_last  = '0;
        forever begin
            @(negedge clk);
            hs = in_valid & in_ready;
            @(posedge clk);
            #2;
            for (int i = 0; i < 4; i++) begin
                if (hs[i]) rq_idx[i]++;
                if (rq_idx[i] < rq_len[i]) begin
                    in_valid[i]       = 1'b1;
                    in_data[i*8 +: 8] = rq_d[i][rq_idx[i]];
                    in_last[i]        = rq_l[i][rq_idx[i]];
                end else begin
                    in_valid[i]       = 1'b0;
                    in_data[i*8 +: 8] = 8'h00;
                    in_last[i]        = 1'b0;
                end
            end
        end
    end

    // Monitor: every sink handshake must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_tot++;
                    $display("FAIL spurious_beat: actual=beat %0h src %0d, required=no beat", out_data, out_src);
                end else begin
                    e = sb.pop_front();
                    check("beat_data", 32'(out_data), 32'(e.d));
                    check("beat_src",  32'(out_src),  32'(e.s));
                    check("beat_last", 32'(out_last), 32'(e.l));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        gnt       = 4'b0010;
        out_ready = 1'b1;
        for (int r = 0; r < 4; r++) rq_len[r] = 0;
        load_req(0, 8'h00, 4, -1);
        load_req(1, 8'h10, 4, -1);
        load_req(2, 8'h20, 4, -1);
        load_req(3, 8'h30, 4, -1);

        // Reset with a live grant and all requesters valid: everything stays quiet.
        smp();
        check("reset_outputs_c1", 32'({out_valid, out_data, out_src, out_last, in_ready, busy, gnt_err}), 32'd0);
        tick();
        smp();
        check("reset_outputs_c2", 32'({out_valid, out_data, out_src, out_last, in_ready, busy, gnt_err}), 32'd0);
        // No in_last from requester 1: the beat budget alone ends the burst on beat 4.
        push(8'h10, 2'd1, 1'b0);
        push(8'h11, 2'd1, 1'b0);
        push(8'h12, 2'd1, 1'b0);
        push(8'h13, 2'd1, 1'b1);
        tick();
        rst = 1'b0;
        tick();
        gnt = 4'b0000;
        smp();
        check("post_reset_busy", 32'(busy), 32'd1);
        check("post_reset_inready", 32'(in_ready), 32'b0010);
        wait_idle("reset_burst_done");
        tick();
        for (int r = 0; r < 4; r++) load_req(r, 8'h00, 0, -1);

        // Full burst from requester 2 with cycle-exact timing.
        tick();
        load_req(2, 8'hA0, 4, 3);
        push(8'hA0, 2'd2, 1'b0);
        push(8'hA1, 2'd2, 1'b0);
        push(8'hA2, 2'd2, 1'b0);
        push(8'hA3, 2'd2, 1'b1);
        tick();
        gnt = 4'b0100;
        tick();
        gnt = 4'b0000;
        smp();
        check("full_n1_state", 32'({busy, in_ready, out_valid}), 32'b1_0100_0);
        tick();
        smp();
        check("full_n2_valid", 32'({out_valid, out_data}), 32'h1A0);
        tick();
        tick();
        tick();
        smp();
        check("full_n5_last", 32'({out_valid, out_last, out_data}), 32'h3A3);
        tick();
        smp();
        check("full_n6_valid_low", 32'(out_valid), 32'd0);
        tick();
        smp();
        check("full_n7_busy_low", 32'(busy), 32'd0);
        wait_idle("full_burst_done");
        tick();
        load_req(2, 8'h00, 0, -1);

        // Early in_last on beat 2 while the grant keeps rotating.
        tick();
        load_req(0, 8'h30, 4, 1);
        load_req(1, 8'h40, 4, -1);
        load_req(2, 8'h50, 4, -1);
        load_req(3, 8'h60, 4, -1);
        push(8'h30, 2'd0, 1'b0);
        push(8'h31, 2'd0, 1'b1);
        tick();
        gnt = 4'b0001;
        tick();
        gnt = 4'b0010;
        smp();
        check("lock_inready_c1", 32'(in_ready[3:1]), 32'd0);
        tick();
        gnt = 4'b0100;
        smp();
        check("lock_inready_c2", 32'(in_ready[3:1]), 32'd0);
        tick();
        gnt = 4'b1000;
        smp();
        check("lock_inready_c3", 32'(in_ready[3:1]), 32'd0);
        tick();
        gnt = 4'b0000;
        smp();
        check("lock_inready_c4", 32'(in_ready[3:1]), 32'd0);
        wait_idle("early_last_done");
        check("early_last_beats_taken", 32'(rq_idx[0]), 32'd2);
        check("others_untouched", 32'(rq_idx[1] + rq_idx[2] + rq_idx[3]), 32'd0);
        tick();
        for (int r = 0; r < 4; r++) load_req(r, 8'h00, 0, -1);

        // Three-cycle sink stall after the second beat.
        tick();
        load_req(3, 8'hB0, 4, -1);
        push(8'hB0, 2'd3, 1'b0);
        push(8'hB1, 2'd3, 1'b0);
        push(8'hB2, 2'd3, 1'b0);
        push(8'hB3, 2'd3, 1'b1);
        tick();
        gnt = 4'b1000;
        tick();
        gnt = 4'b0000;
        tick();
        tick();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            smp();
            check("stall_inready", 32'(in_ready), 32'd0);
            check("stall_hold", 32'({out_valid, out_src, out_data}), 32'h7B1);
            tick();
        end
        out_ready = 1'b1;
        wait_idle("backpressure_done");
        tick();
        load_req(3, 8'h00, 0, -1);

        // Multi-hot grant is rejected and flagged; flag survives a legal burst.
        smp();
        check("gnt_err_clear", 32'(gnt_err), 32'd0);
        tick();
        gnt = 4'b0011;
        tick();
        gnt = 4'b0000;
        smp();
        check("illegal_gnt", 32'({busy, gnt_err, in_ready}), 32'b0_1_0000);
        tick();
        load_req(1, 8'hC0, 1, 0);
        push(8'hC0, 2'd1, 1'b1);
        tick();
        gnt = 4'b0010;
        tick();
        gnt = 4'b0000;
        wait_idle("legal_after_illegal");
        check("gnt_err_sticky", 32'(gnt_err), 32'd1);
        tick();
        load_req(1, 8'h00, 0, -1);

        // Reset while beat 1 is held under a stall; beat is discarded.
        tick();
        load_req(2, 8'hD0, 4, -1);
        out_ready = 1'b0;
        tick();
        gnt = 4'b0100;
        tick();
        gnt = 4'b0000;
        tick();
        smp();
        check("midburst_held", 32'({out_valid, out_data}), 32'h1D0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        smp();
        check("midburst_reset", 32'({out_valid, busy, in_ready, gnt_err}), 32'd0);
        // Fresh burst must run the full four beats, proving the counter restarted.
        tick();
        load_req(2, 8'hE0, 4, -1);
        out_ready = 1'b1;
        push(8'hE0, 2'd2, 1'b0);
        push(8'hE1, 2'd2, 1'b0);
        push(8'hE2, 2'd2, 1'b0);
        push(8'hE3, 2'd2, 1'b1);
        tick();
        gnt = 4'b0100;
        tick();
        gnt = 4'b0000;
        wait_idle("fresh_burst_done");

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
